// File: rtl/ssd_bcd_display_pkg.sv
// Shared definitions for the BCD seven-segment display stage: FSM encoding,
// active-low segment/anode patterns and the double-dabble digit adjust step.
package ssd_bcd_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Segment patterns, active-low, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_UNITS     = 4'b1110;
  localparam logic [3:0] AN_TENS      = 4'b1101;
  localparam logic [3:0] AN_HUNDREDS  = 4'b1011;
  localparam logic [3:0] AN_THOUSANDS = 4'b0111;
  localparam logic [3:0] AN_OFF       = 4'b1111;

  // Pre-shift correction: any BCD nibble >= 5 would overflow a decimal digit
  // when doubled, so bias it by 3 first.
  function automatic logic [15:0] dd_adjust(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal nibbles drive all segments off.
module seven_seg_decoder
  import ssd_bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_bcd_display.sv
// Binary-to-BCD (iterative double dabble) plus 4-digit multiplexed display.
// Optional macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ssd_bcd_display
  import ssd_bcd_display_pkg::*;
#(
  parameter int VALUE_W      = 13,
  parameter int REFRESH_BITS = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value_in,
  output logic [3:0]         anode,
  output logic [6:0]         seg,
  output logic               dp,
  output logic               busy,
  output logic [15:0]        bcd_out
);

  if (VALUE_W > 13) begin : g_value_w_check
    $error("VALUE_W must be <= 13 so the result fits in four digits");
  end

  state_t                  state;
  logic                    force_conv;
  logic [VALUE_W-1:0]      last_value;
  logic [VALUE_W-1:0]      captured;
  logic [VALUE_W-1:0]      shift_reg;
  logic [15:0]             scratch;
  logic [3:0]              iter;
  logic [REFRESH_BITS-1:0] refresh_cnt;

  logic [1:0]              sel;
  logic [3:0]              digit;
  logic [3:0]              anode_next;
  logic [6:0]              dec_seg;
  logic                    blank;
  logic [16+VALUE_W-1:0]   shifted;

  assign sel     = refresh_cnt[REFRESH_BITS-1 -: 2];
  assign shifted = {dd_adjust(scratch), shift_reg} << 1;

  always_comb begin
    digit      = bcd_out[3:0];
    anode_next = AN_UNITS;
    case (sel)
      2'd0: begin digit = bcd_out[3:0];   anode_next = AN_UNITS;     end
      2'd1: begin digit = bcd_out[7:4];   anode_next = AN_TENS;      end
      2'd2: begin digit = bcd_out[11:8];  anode_next = AN_HUNDREDS;  end
      default: begin digit = bcd_out[15:12]; anode_next = AN_THOUSANDS; end
    endcase
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A digit is blank only when it and everything above it are zero; units always shows.
  always_comb begin
    blank = 1'b0;
    case (sel)
      2'd1:    blank = (bcd_out[15:4] == 12'd0);
      2'd2:    blank = (bcd_out[15:8] == 8'd0);
      2'd3:    blank = (bcd_out[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  seven_seg_decoder u_dec (
    .digit (digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      force_conv  <= 1'b1;
      last_value  <= '0;
      captured    <= '0;
      shift_reg   <= '0;
      scratch     <= '0;
      iter        <= '0;
      refresh_cnt <= '0;
      anode       <= AN_OFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      busy        <= 1'b0;
      bcd_out     <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
      anode       <= anode_next;
      seg         <= blank ? SEG_BLANK : dec_seg;
      dp          <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (force_conv || (value_in != last_value)) begin
            captured   <= value_in;
            shift_reg  <= value_in;
            scratch    <= '0;
            iter       <= '0;
            force_conv <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch   <= shifted[VALUE_W +: 16];
          shift_reg <= shifted[VALUE_W-1:0];
          iter      <= iter + 4'd1;
          if (iter == 4'(VALUE_W - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd_out    <= scratch;
          last_value <= captured;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_bcd_display.sv
// Directed bench for ssd_bcd_display with a 4-bit refresh counter
// (four cycles per digit, 16-cycle full scan).
module tb_ssd_bcd_display;
  import ssd_bcd_display_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] value_in;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic [15:0] bcd_out;

  int passed = 0;
  int total  = 0;

  ssd_bcd_display #(.VALUE_W(13), .REFRESH_BITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .anode    (anode),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy),
    .bcd_out  (bcd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask

  // Call at a negedge with the IDLE-state stimulus already applied.
  task automatic wait_conv(input string tag, input logic [15:0] exp);
    int n;
    n = 0;
    for (int i = 0; i < 5 && !busy; i++) @(negedge clk);
    check({tag, "_busy_rise"}, 16'(busy), 16'd1);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 16'(n), 16'd14);
    check({tag, "_bcd"}, bcd_out, exp);
  endtask

  task automatic check_scan(input string tag, input logic [3:0] an, input logic [6:0] sg);
    bit found;
    found = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !found; i++) begin
      if (anode == an) found = 1;
      else @(negedge clk);
    end
    check({tag, "_anode"}, 16'(anode), 16'(an));
    check({tag, "_seg"}, 16'(seg), 16'(sg));
  endtask

  initial begin
    rst      = 1'b0;
    value_in = 13'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_anode", 16'(anode), 16'h000f);
    check("rst_seg",   16'(seg),   16'h007f);
    check("rst_dp",    16'(dp),    16'd1);
    check("rst_busy",  16'(busy),  16'd0);
    check("rst_bcd",   bcd_out,    16'h0000);

    rst = 1'b1;
    wait_conv("force0", 16'h0000);
    check_scan("zero_units", 4'b1110, 7'b1000000);

    value_in = 13'd1234;
    wait_conv("v1234", 16'h1234);
    check_scan("v1234_units", 4'b1110, 7'b0011001);
    check_scan("v1234_tens",  4'b1101, 7'b0110000);
    check_scan("v1234_hund",  4'b1011, 7'b0100100);
    check_scan("v1234_thou",  4'b0111, 7'b1111001);
    check("dp_off", 16'(dp), 16'd1);

    value_in = 13'd8191;
    wait_conv("v8191", 16'h8191);
    check_scan("v8191_thou", 4'b0111, 7'b0000000);

    value_in = 13'd9;
    wait_conv("v9", 16'h0009);
    check_scan("v9_units", 4'b1110, 7'b0010000);

    // Back-to-back: the change to 4095 lands mid-conversion and waits for IDLE.
    value_in = 13'd100;
    @(posedge clk);
    repeat (5) @(negedge clk);
    value_in = 13'd4095;
    repeat (9) @(negedge clk);
    check("b2b_k13_bcd",  bcd_out,      16'h0009);
    check("b2b_k13_busy", 16'(busy),    16'd1);
    @(negedge clk);
    check("b2b_k14_bcd",  bcd_out,      16'h0100);
    check("b2b_k14_busy", 16'(busy),    16'd0);
    @(negedge clk);
    check("b2b_k15_busy", 16'(busy),    16'd1);
    repeat (13) @(negedge clk);
    check("b2b_k28_bcd",  bcd_out,      16'h0100);
    @(negedge clk);
    check("b2b_k29_bcd",  bcd_out,      16'h4095);
    check("b2b_k29_busy", 16'(busy),    16'd0);

    // Reset lands at SHIFT iteration 6 and abandons the conversion.
    value_in = 13'd777;
    @(posedge clk);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_bcd",   bcd_out,      16'h0000);
    check("midrst_busy",  16'(busy),    16'd0);
    check("midrst_anode", 16'(anode),   16'h000f);
    rst = 1'b1;
    wait_conv("v777", 16'h0777);

    value_in = 13'd7;
    wait_conv("v7", 16'h0007);
    check_scan("v7_units", 4'b1110, 7'b1111000);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    check_scan("v7_tens", 4'b1101, 7'b1111111);
    check_scan("v7_hund", 4'b1011, 7'b1111111);
    check_scan("v7_thou", 4'b0111, 7'b1111111);
`else
    check_scan("v7_tens", 4'b1101, 7'b1000000);
    check_scan("v7_hund", 4'b1011, 7'b1000000);
    check_scan("v7_thou", 4'b0111, 7'b1000000);
`endif

    value_in = 13'd0;
    wait_conv("v0", 16'h0000);
    check_scan("v0_units", 4'b1110, 7'b1000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
